// File: rtl/manual_trigger_pkg.sv
// Shared types and defaults for the front-panel push-button conditioning blocks.
package manual_trigger_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } dbnc_state_t;

    // 1 ms of stability at a 50 MHz Clock
    localparam int DBNC_STABLE_DEFAULT = 50000;

endpackage : manual_trigger_pkg

// File: rtl/manual_trigger_debounce_if.sv
// Button-side signal bundle of the debouncer: raw input and enable in, clean level and strobes out.
interface manual_trigger_debounce_if;

    logic EN;
    logic Btn_raw;
    logic Btn_clean;
    logic Press_pulse;
    logic Release_pulse;

    modport master (
        output EN,
        output Btn_raw,
        input  Btn_clean,
        input  Press_pulse,
        input  Release_pulse
    );

    modport slave (
        input  EN,
        input  Btn_raw,
        output Btn_clean,
        output Press_pulse,
        output Release_pulse
    );

endinterface : manual_trigger_debounce_if

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous front-panel inputs, with a synchronous clear.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;

    // Next values of both stages; clear flushes the pipeline to 0.
    always_comb begin
        sync1_d = 1'b0;
        sync2_d = 1'b0;
        if (clr) begin
            sync1_d = 1'b0;
            sync2_d = 1'b0;
        end else begin
            sync1_d = d;
            sync2_d = sync1_q;
        end
    end

    // Synchroniser stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule : sync_2ff

// File: rtl/manual_trigger_debounce.sv
// Push-button debouncer: synchronises Btn_raw, qualifies each level change over
// STABLE_CYCLES samples and emits a clean level plus press/release strobes.
module manual_trigger_debounce
    import manual_trigger_pkg::*;
#(
    parameter int STABLE_CYCLES = DBNC_STABLE_DEFAULT
) (
    input logic                      Clock,
    input logic                      Reset_n,
    manual_trigger_debounce_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic        sync2_s;
    dbnc_state_t state_d;
    dbnc_state_t state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic        clean_d;
    logic        clean_q;
    logic        press_d;
    logic        press_q;
    logic        rel_d;
    logic        rel_q;

    sync_2ff u_sync (
        .clk   (Clock),
        .rst_n (Reset_n),
        .clr   (~bus.EN),
        .d     (bus.Btn_raw),
        .q     (sync2_s)
    );

    // Qualification FSM; EN low overrides everything and drops to RELEASED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (!bus.EN) begin
            state_d = ST_RELEASED;
            cnt_d   = ZERO_CNT;
            clean_d = 1'b0;
        end else begin
            case (state_q)
                ST_RELEASED: begin
                    cnt_d = ZERO_CNT;
                    if (sync2_s) begin
                        state_d = ST_PRESS_WAIT;
                    end else begin
                        state_d = ST_RELEASED;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sync2_s) begin
                        state_d = ST_RELEASED;
                        cnt_d   = ZERO_CNT;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = ST_PRESSED;
                        cnt_d   = ZERO_CNT;
                        clean_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
                ST_PRESSED: begin
                    cnt_d = ZERO_CNT;
                    if (!sync2_s) begin
                        state_d = ST_RELEASE_WAIT;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sync2_s) begin
                        state_d = ST_PRESSED;
                        cnt_d   = ZERO_CNT;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = ST_RELEASED;
                        cnt_d   = ZERO_CNT;
                        clean_d = 1'b0;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE_CNT;
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = ZERO_CNT;
                    clean_d = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_RELEASED;
            cnt_q   <= ZERO_CNT;
            clean_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign bus.Btn_clean     = clean_q;
    assign bus.Press_pulse   = press_q;
    assign bus.Release_pulse = rel_q;

endmodule : manual_trigger_debounce

// File: tb/tb_manual_trigger_debounce.sv
// Bench for manual_trigger_debounce: one instance at STABLE_CYCLES=4, one at the STABLE_CYCLES=1 boundary.
module tb_manual_trigger_debounce;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic Clock;
    logic Reset_n;
    int   total;
    int   bad;

    manual_trigger_debounce_if bus0 ();
    manual_trigger_debounce_if bus1 ();

    manual_trigger_debounce #(.STABLE_CYCLES(S0)) dut0 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus0)
    );

    manual_trigger_debounce #(.STABLE_CYCLES(S1)) dut1 (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference: a level change is accepted once the synchronised input has
    // disagreed with the clean level for STABLE_CYCLES+1 consecutive samples.
    logic m_sync1 [2];
    logic m_sync2 [2];
    logic m_clean [2];
    logic m_press [2];
    logic m_rel   [2];
    int   m_streak[2];
    int   m_s     [2];

    task automatic model_clear();
        for (int j = 0; j < 2; j++) begin
            m_sync1[j] = 1'b0; m_sync2[j] = 1'b0; m_clean[j] = 1'b0;
            m_press[j] = 1'b0; m_rel[j] = 1'b0; m_streak[j] = 0;
        end
    endtask

    task automatic model_edge(input logic raw, input logic en);
        for (int j = 0; j < 2; j++) begin
            m_press[j] = 1'b0;
            m_rel[j]   = 1'b0;
            if (!en) begin
                m_sync1[j] = 1'b0; m_sync2[j] = 1'b0; m_clean[j] = 1'b0; m_streak[j] = 0;
            end else begin
                if (m_sync2[j] != m_clean[j]) begin
                    m_streak[j] = m_streak[j] + 1;
                    if (m_streak[j] == m_s[j] + 1) begin
                        m_clean[j]  = ~m_clean[j];
                        m_press[j]  = m_clean[j];
                        m_rel[j]    = ~m_clean[j];
                        m_streak[j] = 0;
                    end
                end else begin
                    m_streak[j] = 0;
                end
                m_sync2[j] = m_sync1[j];
                m_sync1[j] = raw;
            end
        end
    endtask

    // Drive between edges, advance one rising edge, settle 1 time unit past it.
    task automatic step(input logic raw, input logic en);
        @(negedge Clock);
        bus0.Btn_raw = raw; bus0.EN = en;
        bus1.Btn_raw = raw; bus1.EN = en;
        @(posedge Clock);
        model_edge(raw, en);
        #1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        bus0.Btn_raw = 1'b0; bus0.EN = 1'b0;
        bus1.Btn_raw = 1'b0; bus1.EN = 1'b0;
        model_clear();
        #2;
        total++;
        if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== 3'b000) begin
            bad++; $display("FAIL reset_s4 got %b want 000", {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse});
        end
        bus0.Btn_raw = 1'b1; bus0.EN = 1'b1;
        bus1.Btn_raw = 1'b1; bus1.EN = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        total++;
        if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== 3'b000) begin
            bad++; $display("FAIL reset_held_s1 got %b want 000", {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse});
        end
        bus0.Btn_raw = 1'b0; bus1.Btn_raw = 1'b0;
        @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    task automatic test_clean_press();
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== {i >= 6, i == 6, 1'b0}) begin
                bad++; $display("FAIL clean_press edge %0d got %b want %b", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse}, {i >= 6, i == 6, 1'b0});
            end
            total++;
            if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== {m_clean[1], m_press[1], m_rel[1]}) begin
                bad++; $display("FAIL clean_press_s1 edge %0d got %b want %b", i, {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse}, {m_clean[1], m_press[1], m_rel[1]});
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        pat = 5'b10101;
        step(1'b0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            step((i < 5) ? pat[4 - i] : 1'b1, 1'b1);
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== {i >= 10, i == 10, 1'b0}) begin
                bad++; $display("FAIL bounce edge %0d got %b want %b", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse}, {i >= 10, i == 10, 1'b0});
            end
            total++;
            if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== {m_clean[1], m_press[1], m_rel[1]}) begin
                bad++; $display("FAIL bounce_s1 edge %0d got %b want %b", i, {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse}, {m_clean[1], m_press[1], m_rel[1]});
            end
        end
    endtask

    task automatic test_release();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== {i < 6, 1'b0, i == 6}) begin
                bad++; $display("FAIL release edge %0d got %b want %b", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse}, {i < 6, 1'b0, i == 6});
            end
            total++;
            if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== {m_clean[1], m_press[1], m_rel[1]}) begin
                bad++; $display("FAIL release_s1 edge %0d got %b want %b", i, {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse}, {m_clean[1], m_press[1], m_rel[1]});
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 12; i++) begin
            step(i < 3, 1'b1);
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== 3'b000) begin
                bad++; $display("FAIL glitch edge %0d got %b want 000", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse});
            end
            total++;
            if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== {m_clean[1], m_press[1], m_rel[1]}) begin
                bad++; $display("FAIL glitch_s1 edge %0d got %b want %b", i, {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse}, {m_clean[1], m_press[1], m_rel[1]});
            end
        end
    endtask

    task automatic test_en_drop();
        step(1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            step(1'b1, !(i == 5 || i == 6));
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== {i >= 13, i == 13, 1'b0}) begin
                bad++; $display("FAIL en_drop edge %0d got %b want %b", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse}, {i >= 13, i == 13, 1'b0});
            end
            total++;
            if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== {m_clean[1], m_press[1], m_rel[1]}) begin
                bad++; $display("FAIL en_drop_s1 edge %0d got %b want %b", i, {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse}, {m_clean[1], m_press[1], m_rel[1]});
            end
        end
    endtask

    task automatic test_async_reset();
        total++;
        if (bus0.Btn_clean !== 1'b1) begin
            bad++; $display("FAIL async_pre got %b want 1", bus0.Btn_clean);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        model_clear();
        total++;
        if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse, bus1.Btn_clean} !== 4'b0000) begin
            bad++; $display("FAIL async_reset got %b want 0000", {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse, bus1.Btn_clean});
        end
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1);
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== 3'b000) begin
                bad++; $display("FAIL async_after edge %0d got %b want 000", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse});
            end
        end
    endtask

    task automatic test_random();
        logic raw;
        logic en;
        int   hold;
        raw  = 1'b0;
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                raw  = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold = hold - 1;
            en = ($urandom_range(0, 39) != 0);
            step(raw, en);
            total++;
            if ({bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse} !== {m_clean[0], m_press[0], m_rel[0]}) begin
                bad++; $display("FAIL random_s4 step %0d got %b want %b", i, {bus0.Btn_clean, bus0.Press_pulse, bus0.Release_pulse}, {m_clean[0], m_press[0], m_rel[0]});
            end
            total++;
            if ({bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse} !== {m_clean[1], m_press[1], m_rel[1]}) begin
                bad++; $display("FAIL random_s1 step %0d got %b want %b", i, {bus1.Btn_clean, bus1.Press_pulse, bus1.Release_pulse}, {m_clean[1], m_press[1], m_rel[1]});
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        m_s[0]  = S0;
        m_s[1]  = S1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_glitch();
        test_en_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_manual_trigger_debounce
